// File: rtl/hv_cmdq_stream.sv
// rtl/hv_cmdq_stream.sv - CDB command queue: beat ingest with XOR checksum, in-order dispatch and retire
module hv_cmdq_stream #(
    parameter int IO_W       = 64,
    parameter int CDB_W      = 256,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [IO_W-1:0]       in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [IO_W-1:0]       out_data,
    output logic                  out_last,
    output logic [DEPTH_LOG2-1:0] out_tag,
    output logic                  out_err,
    input  logic                  out_ready,
    input  logic                  upd_valid,
    input  logic [DEPTH_LOG2-1:0] upd_tag,
    input  logic [7:0]            upd_status,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           cks_err_cnt
);
    localparam int BEATS = CDB_W / IO_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORDS = IO_W / 32;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [7:0] ST_FREE    = 8'd0;
    localparam logic [7:0] ST_CKS_ERR = 8'd1;
    localparam logic [7:0] ST_READY   = 8'd2;
    localparam logic [7:0] ST_Q2P     = 8'd3;
    localparam logic [7:0] ST_Q2P_ERR = 8'd9;
    localparam logic [7:0] ST_DONE    = 8'd12;

    typedef enum logic {IDLE, SEND} state_t;

    // Reset asserts immediately but releases two clocks later, aligned to clk.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [PW-1:0]         head, tail, cur;
    logic [DEPTH_LOG2-1:0] head_slot, tail_slot, cur_slot, upd_off;
    logic [7:0]            slot_status [DEPTH];
    logic [IO_W-1:0]       mem [DEPTH][BEATS];
    logic [BW-1:0]         in_beat, out_beat;
    logic [31:0]           cks_acc, beat_xor, cdb_xor;
    state_t                state;
    logic                  err_r, upd_hit;
    logic                  in_fire, in_done, send_done, upd_ok, upd_cur, retire;

    assign head_slot = head[DEPTH_LOG2-1:0];
    assign tail_slot = tail[DEPTH_LOG2-1:0];
    assign cur_slot  = cur[DEPTH_LOG2-1:0];

    assign count = head - tail;
    assign empty = (head == tail);
    assign full  = (head[DEPTH_LOG2] != tail[DEPTH_LOG2]) && (head_slot == tail_slot);

    always_comb begin
        beat_xor = '0;
        for (int i = 0; i < WORDS; i++) beat_xor = beat_xor ^ in_data[i*32 +: 32];
    end
    assign cdb_xor = (in_beat == '0) ? beat_xor : (cks_acc ^ beat_xor);

    assign in_ready = rst_n && ((in_beat != '0) || !full);
    assign in_fire  = in_valid && in_ready;
    assign in_done  = in_fire && (in_beat == LAST_BEAT);

    // Offset from tail below count means the tag lies in the occupied window [tail, head).
    assign upd_off   = upd_tag - tail_slot;
    assign upd_ok    = upd_valid && (upd_status != ST_FREE) && ({1'b0, upd_off} < count);
    assign upd_cur   = upd_ok && (upd_tag == cur_slot);
    assign send_done = (state == SEND) && out_ready && (out_beat == LAST_BEAT);
    assign retire    = !empty && (slot_status[tail_slot] == ST_DONE)
                     && !(upd_valid && (upd_tag == tail_slot))
                     && !((state == SEND) && (cur_slot == tail_slot));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_beat     <= '0;
            cks_acc     <= '0;
            head        <= '0;
            cks_err_cnt <= '0;
        end else if (in_fire) begin
            cks_acc <= cdb_xor;
            if (in_beat == LAST_BEAT) begin
                in_beat <= '0;
                head    <= head + 1'b1;
                if ((cdb_xor != '0) && (cks_err_cnt != 16'hFFFF))
                    cks_err_cnt <= cks_err_cnt + 1'b1;
            end else begin
                in_beat <= in_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem[head_slot][in_beat] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      tail <= '0;
        else if (retire) tail <= tail + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            out_beat <= '0;
            err_r    <= 1'b0;
            upd_hit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (retire && (cur == tail)) begin
                        cur <= tail + 1'b1;
                    end else if (cur != head) begin
                        if ((slot_status[cur_slot] == ST_READY) || (slot_status[cur_slot] == ST_CKS_ERR)) begin
                            state    <= SEND;
                            out_beat <= '0;
                            err_r    <= (slot_status[cur_slot] == ST_CKS_ERR);
                            upd_hit  <= 1'b0;
                        end else begin
                            cur <= cur + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (upd_cur) upd_hit <= 1'b1;
                    if (out_ready) begin
                        if (out_beat == LAST_BEAT) begin
                            state <= IDLE;
                            cur   <= cur + 1'b1;
                            err_r <= 1'b0;
                        end else begin
                            out_beat <= out_beat + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Later writes win: an update overrides the end-of-send write to the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_status[i] <= ST_FREE;
        end else begin
            if (in_done) slot_status[head_slot] <= (cdb_xor == '0) ? ST_READY : ST_CKS_ERR;
            if (send_done && !upd_hit && !upd_cur) slot_status[cur_slot] <= err_r ? ST_Q2P_ERR : ST_Q2P;
            if (retire) slot_status[tail_slot] <= ST_FREE;
            if (upd_ok) slot_status[upd_tag] <= upd_status;
        end
    end

    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? mem[cur_slot][out_beat] : '0;
    assign out_last  = out_valid && (out_beat == LAST_BEAT);
    assign out_tag   = cur_slot;
    assign out_err   = err_r;
endmodule

// File: tb/tb_hv_cmdq_stream.sv
// tb/tb_hv_cmdq_stream.sv - self-checking bench for hv_cmdq_stream against a queue-level model
module tb_hv_cmdq_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic [4:0]  out_tag;
    logic        out_err;
    logic        out_ready = 1'b0;
    logic        upd_valid = 1'b0;
    logic [4:0]  upd_tag = '0;
    logic [7:0]  upd_status = '0;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] cks_err_cnt;

    always #5 clk = ~clk;

    hv_cmdq_stream dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_tag(out_tag), .out_err(out_err), .out_ready(out_ready),
        .upd_valid(upd_valid), .upd_tag(upd_tag), .upd_status(upd_status),
        .count(count), .full(full), .empty(empty), .cks_err_cnt(cks_err_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: occupied window as plain integers, per-slot status codes, and a queue of CDBs owed to dispatch.
    typedef struct {
        logic [255:0] d;
        int           tag;
        bit           err;
    } cdb_t;

    cdb_t         exp_q[$];
    logic [7:0]   m_stat[32];
    logic [255:0] m_cdb;
    int m_head, m_tail, m_beat, m_sync, m_cks, m_b;
    bit m_hit;

    function automatic logic [31:0] xor8(input logic [255:0] d);
        logic [31:0] x = '0;
        for (int i = 0; i < 8; i++) x ^= d[i*32 +: 32];
        return x;
    endfunction

    function automatic logic [255:0] mk_cdb(input bit corrupt);
        logic [255:0] d;
        logic [31:0]  x = '0;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        for (int i = 0; i < 7; i++) x ^= d[i*32 +: 32];
        d[255:224] = x;
        if (corrupt) d[0] = ~d[0];
        return d;
    endfunction

    task automatic model_step();
        int  cnt, ts;
        bit  ok, rdy, upd_acc, ret;
        if (!reset) begin
            exp_q.delete();
            foreach (m_stat[i]) m_stat[i] = 8'd0;
            m_head = 0; m_tail = 0; m_beat = 0; m_sync = 0; m_cks = 0; m_b = 0; m_hit = 0;
            return;
        end
        ok  = (m_sync >= 2);
        cnt = m_head - m_tail;
        rdy = ok && (m_beat != 0 || cnt < 32);
        ts  = m_tail % 32;
        upd_acc = ok && upd_valid && (upd_status != 8'd0) && (((int'(upd_tag) - m_tail) & 31) < cnt);
        ret = ok && (cnt > 0) && (m_stat[ts] == 8'd12) && !(upd_valid && int'(upd_tag) == ts)
              && !(out_valid && exp_q.size() > 0 && exp_q[0].tag == ts);
        if (rdy && in_valid) begin
            m_cdb[m_beat*64 +: 64] = in_data;
            if (m_beat == 3) begin
                cdb_t c;
                c.d = m_cdb; c.tag = m_head % 32; c.err = (xor8(m_cdb) != 0);
                m_stat[c.tag] = c.err ? 8'd1 : 8'd2;
                if (c.err && m_cks < 16'hFFFF) m_cks++;
                exp_q.push_back(c);
                m_head++;
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (ok && out_valid && exp_q.size() > 0) begin
            if (upd_acc && int'(upd_tag) == exp_q[0].tag) m_hit = 1;
            if (out_ready) begin
                if (m_b == 3) begin
                    if (!m_hit) m_stat[exp_q[0].tag] = exp_q[0].err ? 8'd9 : 8'd3;
                    void'(exp_q.pop_front());
                    m_b = 0; m_hit = 0;
                end else begin
                    m_b++;
                end
            end
        end
        if (ret) begin
            m_stat[ts] = 8'd0;
            m_tail++;
        end
        if (upd_acc) m_stat[upd_tag] = upd_status;
        if (m_sync < 2) m_sync++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check_cycle();
        int  cnt, badslot;
        bit  ok;
        if (!reset) begin
            chk("reset_outputs",
                {in_ready, out_valid, out_last, out_err, out_tag, full, empty, count, cks_err_cnt, out_data},
                {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'd0, 16'd0, 64'd0});
            return;
        end
        ok  = (m_sync >= 2);
        cnt = m_head - m_tail;
        chk("count", count, cnt);
        chk("full", full, cnt == 32);
        chk("empty", empty, cnt == 0);
        chk("cks_err_cnt", cks_err_cnt, m_cks);
        chk("in_ready", in_ready, ok && (m_beat != 0 || cnt < 32));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                chk("out_data", out_data, exp_q[0].d[m_b*64 +: 64]);
                chk("out_tag", out_tag, exp_q[0].tag);
                chk("out_err", out_err, exp_q[0].err);
                chk("out_last", out_last, m_b == 3);
            end
        end
        badslot = -1;
        for (int i = 0; i < 32; i++)
            if (badslot < 0 && dut.slot_status[i] !== m_stat[i]) badslot = i;
        if (badslot >= 0) chk($sformatf("status[%0d]", badslot), dut.slot_status[badslot], m_stat[badslot]);
        else              chk("status_array", 1'b1, 1'b1 && (badslot < 0));
    endtask

    initial forever begin
        @(negedge clk);
        check_cycle();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cdb(input logic [255:0] d, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            bit acc = 0;
            int n = 0;
            in_valid = 1'b1;
            in_data  = d[i*64 +: 64];
            while (!acc && n < 300) begin
                @(posedge clk);
                acc = in_ready;
                #1;
                n++;
            end
            chk("in_ready_wait", acc, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_until_last();
        bit h = 0;
        int n = 0;
        out_ready = 1'b1;
        while (!h && n < 300) begin
            @(posedge clk);
            h = out_valid && out_last;
            #1;
            n++;
        end
        out_ready = 1'b0;
        chk("last_handshake_seen", h, 1'b1);
    endtask

    task automatic update(input int tag, input logic [7:0] st);
        upd_valid  = 1'b1;
        upd_tag    = 5'(tag);
        upd_status = st;
        tick();
        upd_valid  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d1, d2, d3;
        int n;
        repeat (3) tick();
        chk("reset_empty", empty, 1'b1);
        reset = 1'b1;
        repeat (2) tick();
        chk("post_reset_in_ready", in_ready, 1'b1);

        // Clean CDB: visible one cycle after the last beat, dispatched the cycle after.
        out_ready = 1'b1;
        d1 = mk_cdb(0);
        send_cdb(d1, 4);
        chk("t1_count", count, 6'd1);
        chk("t1_not_yet_valid", out_valid, 1'b0);
        tick();
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_tag", out_tag, 5'd0);
        chk("t1_beat0", out_data, d1[63:0]);
        repeat (3) tick();
        chk("t1_last", out_last, 1'b1);
        chk("t1_beat3", out_data, d1[255:192]);
        tick();
        chk("t1_done", out_valid, 1'b0);
        out_ready = 1'b0;

        // Checksum error CDB.
        d2 = 256'h1;
        send_cdb(d2, 4);
        tick();
        chk("t2_cks_cnt", cks_err_cnt, 16'd1);
        chk("t2_out_err", out_err, 1'b1);
        drain_until_last();
        tick();
        chk("t2_q2p_err", dut.slot_status[1], 8'd9);

        // Out-of-window and FREE updates are ignored; an update during SEND stands.
        update(5, 8'd12);
        update(0, 8'd0);
        chk("t5_slot0_kept", dut.slot_status[0], 8'd3);
        chk("t5_slot5_free", dut.slot_status[5], 8'd0);
        d3 = mk_cdb(0);
        send_cdb(d3, 4);
        tick();
        chk("t5_sending_tag", out_tag, 5'd2);
        update(2, 8'h20);
        drain_until_last();
        tick();
        chk("t5_upd_stands", dut.slot_status[2], 8'h20);

        // Reset mid-SEND with a partial CDB in flight.
        send_cdb(mk_cdb(0), 4);
        tick();
        chk("t6_in_send", out_valid, 1'b1);
        send_cdb(mk_cdb(0), 2);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 1'b0);
        chk("t6_async_empty", empty, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        d1 = mk_cdb(0);
        send_cdb(d1, 4);
        tick();
        chk("t6_tag0", out_tag, 5'd0);
        chk("t6_data0", out_data, d1[63:0]);
        drain_until_last();
        tick();
        update(0, 8'd12);
        tick();
        chk("t6_retired", empty, 1'b1);

        // Fill all 32 slots while the processor stalls.
        for (int i = 0; i < 32; i++) send_cdb(mk_cdb(i % 7 == 3), 4);
        chk("t3_full", full, 1'b1);
        chk("t3_in_ready", in_ready, 1'b0);
        drain_until_last();
        update(1, 8'd12);
        tick();
        chk("t3_count31", count, 6'd31);
        chk("t3_in_ready_back", in_ready, 1'b1);

        // Toggle out_ready every cycle until every CDB is delivered.
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            out_ready = n[0];
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("t4_all_delivered", exp_q.size(), 0);

        // Retire everything, wrapping the pointers.
        for (int i = 2; i < 33; i++) update(i % 32, 8'd12);
        repeat (2) tick();
        chk("final_empty", empty, 1'b1);
        chk("final_count", count, 6'd0);
        chk("final_cks_cnt", cks_err_cnt, 16'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
